// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared constants and types for the LED pattern engine and
//               related board-level blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  // Pattern modes, sampled on every tick
  localparam logic [1:0] MODE_ROR    = 2'b00;
  localparam logic [1:0] MODE_ROL    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  // Bounce direction
  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // Counter width able to hold 0 .. div-1 (never narrower than one bit)
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_engine_if
// Description : Control and LED bus between board switches/buttons and the
//               LED pattern engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_pattern_engine_if #(
  parameter int WIDTH = 16
);

  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] led;
  logic             step;

  // Board side: drives controls, observes the LED bank
  modport master (
    output en, mode, load, load_val,
    input  led, step
  );

  // Engine side
  modport slave (
    input  en, mode, load, load_val,
    output led, step
  );

endinterface
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Enable-gated tick divider. Emits a one-cycle tick every DIV
//               enabled cycles; pausing holds the phase, clr restarts it.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
  import led_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,   // asynchronous, active low
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Tick fires on the terminal count only while enabled
  assign tick = en && (cnt == LAST);

  // Phase counter: clear wins, then wrap on tick, else count while enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_engine
// Description : WIDTH-bit LED pattern generator stepping once per tick in
//               rotate-right, rotate-left, bounce or blink mode, with a
//               synchronous pattern load and a registered step strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               TICK_DIV = 67108864,
  parameter logic [WIDTH-1:0] INIT     = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic                 clk,
  input  logic                 rst,   // asynchronous, active low
  led_pattern_engine_if.slave  bus
);

  logic             tick;
  logic [WIDTH-1:0] led_q, led_d;
  dir_e             bdir_q, bdir_d;
  logic             step_q, step_d;

  // Shared divider; a load restarts the period from zero
  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .tick (tick)
  );

  // Next pattern: load beats tick, tick beats hold
  always_comb begin
    led_d  = led_q;
    bdir_d = bdir_q;
    step_d = 1'b0;
    if (bus.load) begin
      led_d  = bus.load_val;
      bdir_d = DIR_RIGHT;
    end else if (tick) begin
      step_d = 1'b1;
      case (bus.mode)
        MODE_ROR: led_d = {led_q[0], led_q[WIDTH-1:1]};
        MODE_ROL: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        MODE_BOUNCE: begin
          // Both edges lit: nowhere to go, so pattern and direction hold
          if (!(led_q[0] && led_q[WIDTH-1])) begin
            if (bdir_q == DIR_RIGHT) begin
              if (led_q[0]) begin
                bdir_d = DIR_LEFT;
                led_d  = led_q << 1;
              end else begin
                led_d  = led_q >> 1;
              end
            end else begin
              if (led_q[WIDTH-1]) begin
                bdir_d = DIR_RIGHT;
                led_d  = led_q >> 1;
              end else begin
                led_d  = led_q << 1;
              end
            end
          end
        end
        default: led_d = ~led_q;
      endcase
    end
  end

  // Pattern, direction and strobe registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q  <= INIT;
      bdir_q <= DIR_RIGHT;
      step_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      bdir_q <= bdir_d;
      step_q <= step_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.step = step_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_engine
// Description : Scoreboard bench for led_pattern_engine (WIDTH=8, TICK_DIV=4).
//               A reference model predicts each step; a monitor checks the
//               LED value and timing of every step pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_engine;

  localparam int W   = 8;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_pattern_engine_if #(.WIDTH(W)) bus ();

  led_pattern_engine #(
    .WIDTH    (W),
    .TICK_DIV (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    time t;
    int  led;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: pattern as an integer, elapsed enabled cycles in
  // the current period, and bounce heading (1 = moving left / upwards)
  int m_led;
  int m_phase;
  bit m_left;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led   = 1 << (W - 1);
    m_phase = 0;
    m_left  = 1'b0;
  endtask

  // One step of the selected mode, written as plain arithmetic on the value
  task automatic model_step(input int md);
    int top;
    top = 1 << (W - 1);
    case (md)
      0: m_led = m_led / 2 + (m_led % 2) * top;
      1: m_led = (m_led * 2) % (2 * top) + m_led / top;
      2: begin
        if (m_led != 0 && !((m_led % 2 == 1) && (m_led >= top))) begin
          if (!m_left) begin
            if (m_led % 2 == 1) begin m_left = 1'b1; m_led = (m_led * 2) % (2 * top); end
            else                       m_led = m_led / 2;
          end else begin
            if (m_led >= top) begin m_left = 1'b0; m_led = m_led / 2; end
            else                     m_led = (m_led * 2) % (2 * top);
          end
        end
      end
      default: m_led = (2 * top - 1) - m_led;
    endcase
  endtask

  // Advance the model on a clock edge using the inputs the DUT just sampled
  task automatic model_edge();
    exp_t e;
    if (!rst) begin
      model_reset();
    end else if (bus.load) begin
      m_led   = int'(bus.load_val);
      m_phase = 0;
      m_left  = 1'b0;
    end else if (bus.en) begin
      if (m_phase == DIV - 1) begin
        m_phase = 0;
        model_step(int'(bus.mode));
        e.t   = $time;
        e.led = m_led;
        q.push_back(e);
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge
  task automatic do_reset();
    #2;
    rst = 1'b0;
    q.delete();
    model_reset();
    #1;
    check("async_rst_led", int'(bus.led), 1 << (W - 1));
    check("async_rst_step", int'(bus.step), 0);
    run(2);
    rst = 1'b1;
  endtask

  // Monitor: every step pulse must match the oldest prediction in value and
  // in time (visible half a cycle after the predicting edge)
  always @(negedge clk) begin
    if (bus.step) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: step=1 led=0x%0h, expected no step at %0t", bus.led, $time);
      end else begin
        mon_e = q.pop_front();
        check("step_time", int'($time - mon_e.t), 5);
        check("step_led", int'(bus.led), mon_e.led);
      end
    end else if (q.size() > 0 && q[0].t + 5 <= $time) begin
      mon_e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_step: step=0, expected step with led=0x%0h at %0t", mon_e.led, $time);
    end
  end

  initial begin
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = 2'b00;
    bus.load     = 1'b0;
    bus.load_val = '0;
    model_reset();

    // 1. reset state, then rotate right
    run(3);
    check("reset_led", int'(bus.led), 8'h80);
    check("reset_step", int'(bus.step), 0);
    rst    = 1'b1;
    bus.en = 1'b1;
    run(2);
    check("first_cycles_led", int'(bus.led), 8'h80);
    run(38);

    // 2. rotate left from reset
    do_reset();
    bus.mode = 2'b01;
    run(14);

    // 3. bounce from 0x02, then both edges lit
    bus.load = 1'b1; bus.load_val = 8'h02;
    run(1);
    bus.load = 1'b0; bus.mode = 2'b10;
    run(4 * 17);
    bus.load = 1'b1; bus.load_val = 8'h81;
    run(1);
    bus.load = 1'b0;
    run(20);
    check("bounce_hold_led", int'(bus.led), 8'h81);

    // 4. blink, with a pause two cycles into a period
    bus.load = 1'b1; bus.load_val = 8'hA5; bus.mode = 2'b11;
    run(1);
    bus.load = 1'b0;
    run(9);
    bus.load = 1'b1;
    run(1);
    bus.load = 1'b0;
    run(2);
    bus.en = 1'b0;
    run(10);
    bus.en = 1'b1;
    run(10);

    // 5. load on the same edge as a tick
    for (int i = 0; i < 8 && m_phase != DIV - 1; i++) run(1);
    bus.load = 1'b1; bus.load_val = 8'h10;
    run(1);
    bus.load = 1'b0;
    check("load_on_tick_led", int'(bus.led), 8'h10);
    check("load_on_tick_step", int'(bus.step), 0);
    run(10);

    // 6. asynchronous reset mid-run
    bus.mode = 2'b00;
    run(5);
    do_reset();
    run(10);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      bus.en       = ($urandom_range(0, 7) != 0);
      bus.mode     = 2'($urandom_range(0, 3));
      bus.load     = ($urandom_range(0, 19) == 0);
      bus.load_val = 8'($urandom);
      if (i % 500 == 499) do_reset();
      else                run(1);
    end
    bus.load = 1'b0;
    bus.en   = 1'b1;
    run(8);
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised successor to the board's single-hot LED rotator: drives a WIDTH-bit LED bank and updates it once per programmable tick.
- Modes: rotate right, rotate left, bounce (ping-pong) and blink (invert).
- Supports a synchronous pattern load and a per-update strobe.
- Sits directly between the board switches/buttons and the LED pins; it replaces the external clock divider with an internal tick counter.

Parameters:
- WIDTH, 16, number of LEDs; legal values ≥2.
- TICK_DIV, 67108864, clk cycles per step while enabled; legal values ≥1. 1 means a step every cycle.
- INIT, 1<<(WIDTH-1), pattern loaded on reset (MSB only).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset; asserting it (0) clears state immediately, release is synchronous to clk.
- en  in  1  1 = tick counter runs and pattern steps; 0 = pause (counter and pattern hold).
- mode  in  2  00 rotate right, 01 rotate left, 10 bounce, 11 blink; sampled on each tick.
- load  in  1  synchronous pattern load strobe.
- load_val  in  WIDTH  pattern written by load.
- led  out  WIDTH  current pattern (registered).
- step  out  1  registered pulse, high for exactly the one cycle in which led shows a tick-updated value.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - led=INIT
  - step=0
  - tick counter cnt=0
  - bounce direction bdir=RIGHT
- Tick counter:
  - cnt width is max(1, clog2(TICK_DIV)).
  - If en=1: cnt increments each cycle; tick=1 when cnt==TICK_DIV-1, and cnt wraps to 0 on that cycle.
  - If en=0: cnt holds and tick=0. Pausing preserves phase; the first step after re-enable arrives after the remaining cycles.
- Priority per cycle: load > tick > hold.
- load=1:
  - led<=load_val, cnt<=0, bdir<=RIGHT, step<=0.
  - A tick coinciding with load is discarded.
  - load works regardless of en.
- tick=1 (no load), by mode:
  - 00: led<={led[0], led[W-1:1]} (rotate right, LSB wraps to MSB).
  - 01: led<={led[W-2:0], led[W-1]} (rotate left, MSB wraps to LSB).
  - 10 bounce, shift without wrap; the edge check uses led before the update:
    - bdir=RIGHT and led[0]=1: bdir<=LEFT and led<=led<<1.
    - bdir=RIGHT and led[0]=0: led<=led>>1.
    - bdir=LEFT and led[W-1]=1: bdir<=RIGHT and led<=led>>1.
    - bdir=LEFT and led[W-1]=0: led<=led<<1.
    - If led[0] and led[W-1] are both 1: led and bdir hold.
    - led=0 stays 0.
  - 11: led<=~led.
- step<=tick&~load (one-cycle latency). step pulses on every tick, even if led is unchanged (bounce-hold, all-zero).
- Mode change takes effect at the next tick. bdir is retained across mode changes and is only updated in mode 10, on load or on reset.
- No other input changes led. Outputs are glitch-free registers.

Decomposition:
- Shared package led_pkg:
  - mode constants MODE_ROR=2'b00, MODE_ROL=2'b01, MODE_BOUNCE=2'b10, MODE_BLINK=2'b11
  - bdir encoding DIR_RIGHT=1'b0, DIR_LEFT=1'b1
- One sub-module, tick_gen (parameter DIV): contains cnt, en gating, the load clear input and the tick output. Reused later by other board-level blocks.
- Pattern update is an always-comb next-state block plus one state register bank in the top level.

Test Plan (WIDTH=8, TICK_DIV=4):
1. Release reset, en=1, mode=00 → led=0x80 and step=0 in the first cycles. led then steps 0x40, 0x20, … every 4 cycles, returning to 0x80 after the 8th step; step is high exactly 1 cycle per 4.
2. Reset, en=1, mode=01 → the first step gives led=0x01 (MSB wraps), then 0x02, 0x04.
3. load=1 with load_val=0x02, then mode=10:
   - led sequence is 0x02, 0x01, 0x02, 0x04, …, 0x80, 0x40.
   - Then load 0x81 → led stays 0x81 while step keeps pulsing.
4. load 0xA5, mode=11 → led goes 0xA5, 0x5A, 0xA5. Drop en after 2 cycles into a period, hold it low for 10 cycles, then raise it → the next step occurs exactly 2 cycles after re-enable.
5. Assert load on the same cycle as a tick (load_val=0x10) → led=0x10 and step=0. The next step comes 4 cycles later.
6. Pull rst low between clock edges mid-run → led=0x80 and step=0 immediately, without a clk edge. After release, the first step comes 4 cycles later.
